// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction
// memory and queues {pc, inst} pairs for decode behind a valid/ready handshake.
// Redirects from execute reload the PC and flush every queued fetch.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_inst,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_inst,
  output logic                     fetch_fault,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  // Queue storage; not reset because only entries below count are ever read.
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          fault_q, fault_d;
  logic [31:0]   dec_pc_q, dec_pc_d;
  logic [31:0]   dec_inst_q, dec_inst_d;

  logic          pop;
  logic          in_range;
  logic          space;
  logic          fire;
  logic          fault_set;
  logic [CW-1:0] remaining;

  // Handshake and fetch-qualification terms.
  always_comb begin
    pop       = (count_q != '0) & dec_ready;
    in_range  = (pc_q <= LAST_PC);
    space     = (count_q < CW'(DEPTH)) | pop;
    fire      = fetch_en & ~fault_q & in_range & space & ~redirect_valid;
    fault_set = fetch_en & ~fault_q & ~in_range & ~redirect_valid;
  end

  // Next-state for PC, pointers, occupancy, fault flag and the head output registers.
  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fault_d    = fault_q;
    dec_pc_d   = dec_pc_q;
    dec_inst_d = dec_inst_q;
    remaining  = count_q - CW'(pop);
    if (redirect_valid) begin
      // Flush wins over everything, including a pop offered in the same cycle.
      pc_d    = {redirect_pc[31:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      fault_d = 1'b0;
    end else begin
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (fire) begin
        tail_d = tail_q + 1'b1;
        pc_d   = pc_q + 32'd4;
      end
      if (fault_set) begin
        fault_d = 1'b1;
      end
      count_d = count_q + CW'(fire) - CW'(pop);
      // Head after this cycle: an older entry if one survives, else the word being pushed.
      if (remaining != '0) begin
        dec_pc_d   = q_pc[head_d];
        dec_inst_d = q_inst[head_d];
      end else if (fire) begin
        dec_pc_d   = pc_q;
        dec_inst_d = imem_inst;
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      dec_pc_q   <= '0;
      dec_inst_q <= '0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
      dec_pc_q   <= dec_pc_d;
      dec_inst_q <= dec_inst_d;
    end
  end

  // Queue write at the tail on each fetch.
  always_ff @(posedge clk) begin
    if (fire) begin
      q_pc[tail_q]   <= pc_q;
      q_inst[tail_q] <= imem_inst;
    end
  end

  assign imem_addr   = pc_q;
  assign dec_valid   = (count_q != '0);
  assign dec_pc      = dec_pc_q;
  assign dec_inst    = dec_inst_q;
  assign fetch_fault = fault_q;
  assign queue_count = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a byte-addressed big-endian memory model.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        fetch_fault;
  logic [1:0]  queue_count;

  logic [7:0]  mem [1024];

  int n_vec = 0;
  int n_err = 0;

  inst_fetch #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .MEM_BYTES (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_inst       (dec_inst),
    .fetch_fault    (fetch_fault),
    .queue_count    (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational big-endian memory; out-of-range reads return zero.
  always_comb begin
    imem_inst = 32'h0;
    if (imem_addr <= 32'd1020) begin
      imem_inst = {mem[imem_addr[9:0]], mem[imem_addr[9:0] + 10'd1],
                   mem[imem_addr[9:0] + 10'd2], mem[imem_addr[9:0] + 10'd3]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    mem[addr]     = w[31:24];
    mem[addr + 1] = w[23:16];
    mem[addr + 2] = w[15:8];
    mem[addr + 3] = w[7:0];
  endtask

  initial begin
    // Filler word at address a is 0xA5A5_aaaa so every fetch is identifiable.
    for (int a = 0; a < 1024; a += 4) put_word(a, {16'hA5A5, 16'(a)});
    put_word(0, 32'h0010_0313);
    put_word(4, 32'h0063_0333);
    put_word(32'h20, 32'h100E_6E13);

    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    dec_ready = 1'b1;
    #2;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(dec_valid), 32'h0);
    chk("rst_count", 32'(queue_count), 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Streaming with decode always ready.
    tick();
    chk("t1_valid0", 32'(dec_valid), 32'h1);
    chk("t1_pc0", dec_pc, 32'h0);
    chk("t1_inst0", dec_inst, 32'h0010_0313);
    chk("t1_addr4", imem_addr, 32'h4);
    tick();
    chk("t1_pc4", dec_pc, 32'h4);
    chk("t1_inst4", dec_inst, 32'h0063_0333);
    chk("t1_addr8", imem_addr, 32'h8);

    // Backpressure from reset: queue fills and PC stalls.
    dec_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t2_count_full", 32'(queue_count), 32'h2);
    chk("t2_addr_hold", imem_addr, 32'h8);
    chk("t2_head_pc0", dec_pc, 32'h0);
    chk("t2_head_inst0", dec_inst, 32'h0010_0313);
    dec_ready = 1'b1;
    tick();
    chk("t2_head_pc4", dec_pc, 32'h4);
    chk("t2_count_pp", 32'(queue_count), 32'h2);
    chk("t2_addr_c", imem_addr, 32'hC);
    tick();
    chk("t2_head_pc8", dec_pc, 32'h8);
    chk("t2_head_inst8", dec_inst, 32'hA5A5_0008);

    // Redirect with a full queue; low address bits dropped.
    redirect_valid = 1'b1; redirect_pc = 32'h21;
    tick();
    redirect_valid = 1'b0;
    chk("t3_valid_flush", 32'(dec_valid), 32'h0);
    chk("t3_count_flush", 32'(queue_count), 32'h0);
    chk("t3_addr_20", imem_addr, 32'h20);
    tick();
    chk("t3_pc20", dec_pc, 32'h20);
    chk("t3_inst20", dec_inst, 32'h100E_6E13);

    // Last legal word, then the fault.
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t4_pc3fc", dec_pc, 32'h3FC);
    chk("t4_inst3fc", dec_inst, 32'hA5A5_03FC);
    chk("t4_nofault_yet", 32'(fetch_fault), 32'h0);
    tick();
    chk("t4_fault", 32'(fetch_fault), 32'h1);
    chk("t4_addr400", imem_addr, 32'h400);
    tick();
    chk("t4_no_push", 32'(queue_count), 32'h0);
    chk("t4_addr_hold", imem_addr, 32'h400);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("t4_fault_clr", 32'(fetch_fault), 32'h0);
    tick();
    chk("t4_resume_pc", dec_pc, 32'h0);
    chk("t4_resume_inst", dec_inst, 32'h0010_0313);

    // Full queue, pop and redirect together.
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_full", 32'(queue_count), 32'h2);
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    chk("t5_empty", 32'(queue_count), 32'h0);
    chk("t5_addr10", imem_addr, 32'h10);
    tick();
    chk("t5_head10", dec_pc, 32'h10);
    chk("t5_count1", 32'(queue_count), 32'h1);
    // Fetch disabled: PC frozen, queue drains.
    fetch_en = 1'b0; dec_ready = 1'b0;
    tick();
    chk("t5_frozen", imem_addr, 32'h14);
    dec_ready = 1'b1;
    tick();
    chk("t5_drained", 32'(queue_count), 32'h0);
    chk("t5_frozen2", imem_addr, 32'h14);
    chk("t5_valid0", 32'(dec_valid), 32'h0);

    // Build up a full queue plus a fault, then reset between edges.
    fetch_en = 1'b1; dec_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h3F8;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_pre_count", 32'(queue_count), 32'h2);
    chk("t6_pre_fault", 32'(fetch_fault), 32'h1);
    chk("t6_pre_head", dec_pc, 32'h3F8);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(dec_valid), 32'h0);
    chk("t6_async_count", 32'(queue_count), 32'h0);
    chk("t6_async_fault", 32'(fetch_fault), 32'h0);
    chk("t6_async_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; dec_ready = 1'b1;
    tick();
    chk("t6_restart_pc", dec_pc, 32'h0);
    chk("t6_restart_inst", dec_inst, 32'h0010_0313);
    tick();
    chk("t6_restart_pc4", dec_pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
